countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Next-generation cook timer for the microwave controller: a BCD countdown of MIN_DIGITS minute digits plus tens-of-seconds and seconds digits.
- Keypad digits are shifted in from the right, as on a microwave keypad. The block adds start, pause/resume, cancel, +30 s and quick-start.
- It has its own state machine, so the magnetron control block only watches running and timer_done.
- Single clock; the 1 Hz rate comes in as a tick enable from the prescaler.

Parameters:
- MIN_DIGITS, 2, number of BCD minute digits (legal range 1..4).
- QUICK_START, 1, start pressed with an all-zero value in IDLE loads 0:30 and runs. When 0, that start is ignored.

Ports:
- CLK  in  1  system clock.
- clear  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle 1 Hz count enable.
- digit  in  4  BCD keypad digit.
- digit_valid  in  1  strobe that shifts digit in.
- start  in  1  start/resume strobe.
- pause  in  1  pause strobe.
- cancel  in  1  cancel strobe.
- add30  in  1  add 30 s strobe.
- minutes  out  4*MIN_DIGITS  minute digits; least-significant digit in [3:0].
- tens_secs  out  4  tens-of-seconds digit.
- secs  out  4  seconds digit.
- running  out  1  high in RUN (gates the magnetron).
- paused  out  1  high in PAUSE.
- timer_done  out  1  level, high in DONE.
- done_pulse  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. clear is sampled on the CLK rising edge and has top priority. On clear, all digits = 0, state = IDLE, and all status outputs = 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Same-cycle priority: clear > cancel > pause > start > add30 > digit_valid > tick.
- IDLE, digit entry:
  - digit_valid with digit <= 9 shifts the value left: digit -> secs, secs -> tens_secs, tens_secs -> minutes[0], minutes[k] -> minutes[k+1].
  - The top minute digit is discarded.
  - digit > 9 is ignored.
  - tens_secs may hold 6..9 after entry (e.g. "99" = 99 s); this is legal.
- IDLE, start:
  - Nonzero value -> RUN.
  - Zero value and QUICK_START=1 -> load 0:30, go to RUN.
  - Zero value and QUICK_START=0 -> ignored.
- IDLE, add30 and cancel: add30 performs the +30 s rule; cancel zeroes all digits.
- RUN:
  - tick decrements by 1 s.
  - secs 0 borrows and becomes 9. tens_secs 0 borrows and becomes 5. A minute digit 0 borrows and becomes 9.
  - A nonzero digit simply decrements. A non-normalised tens_secs (6..9) decrements normally.
  - If the decrement produces 0:00, go to DONE in the same edge; done_pulse is high for that one following cycle.
  - pause -> PAUSE, digits held. cancel -> IDLE, digits zeroed. add30 -> +30 s.
  - tick is ignored in every state except RUN.
- PAUSE:
  - start -> RUN.
  - cancel -> IDLE, digits zeroed.
  - add30 -> +30 s, state stays PAUSE.
  - digit_valid is ignored.
- DONE:
  - Digits stay 0 and timer_done stays high.
  - start, cancel or digit_valid -> IDLE with digits 0. The strobe that exits DONE has no other effect.
- +30 s rule:
  - Compute tens_secs + 3. If the result >= 6, subtract 6 and increment the minute chain in BCD with carry.
  - If the minute chain overflows, saturate to all minute digits = 9, tens_secs = 5, secs = 9.
  - add30 is ignored while tens_secs > 5.
- Simultaneous events:
  - add30 and tick in the same RUN cycle: add30 wins and the tick is dropped.
  - pause and tick in the same cycle: pause wins and no decrement happens.

Decomposition:
- Package timer_pkg: state encoding (IDLE/RUN/PAUSE/DONE), BCD constants (BCD_MAX = 9, SEC_TENS_MAX = 5, quick-start value 0:30), and a MIN_DIGITS legality check.
- Sub-module bcd_digit: one BCD digit register with load, shift-in, decrement-with-borrow (MAX parameter 9 or 5), increment-with-carry, and a zero flag. Instantiate it for secs, for tens_secs (MAX=5) and once per minute digit via generate.
- The FSM and the +30 s / saturation logic live in countdown_timer.

Test Plan:
- Entry and countdown: clear; enter digits 1,3,0 (1:30); start; 90 ticks.
  - Display passes 1:00 -> 0:59.
  - Reaches 0:00 on tick 90; timer_done = 1; done_pulse high exactly 1 cycle; running = 0.
- Non-normalised entry: enter 9,9; start; 10 ticks -> 0:89.
  - Continue to 0 after 99 ticks total -> DONE.
- Pause, tick and add30: load 2:10, start, 5 ticks -> 2:05.
  - pause with tick in the same cycle -> 2:05 held, paused = 1.
  - Ticks while paused -> no change.
  - add30 -> 2:35.
  - start -> RUN, resumes from 2:35.
- Quick start and saturation:
  - Zero value, start -> 0:30 RUN.
  - With MIN_DIGITS=2, load 99:45 and add30 -> 99:59 saturated.
  - 99:20 + add30 -> 99:50.
- Digit overflow and illegal digit:
  - Shift in 1,2,3,4,5 with MIN_DIGITS=2 -> 23:45.
  - digit = 4'hC -> ignored.
- Cancel and reset mid-run:
  - cancel in RUN at 0:40 -> IDLE, 0:00, running = 0.
  - clear asserted during DONE -> all outputs 0 on the next edge.
  - In DONE, digit_valid with 7 -> IDLE at 0:00 (digit not entered).

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM states, BCD limits,
// quick-start preset and a MIN_DIGITS legality check.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DIGIT_W-1:0] BCD_MAX       = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX  = 4'd5;
  // +30 s adds 3 to the tens-of-seconds digit; a result of 6 or more carries a minute
  localparam logic [DIGIT_W-1:0] ADD30_TENS    = 4'd3;
  localparam logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd6;
  // Quick-start preset 0:30
  localparam logic [DIGIT_W-1:0] QS_TENS       = 4'd3;
  localparam logic [DIGIT_W-1:0] QS_SECS       = 4'd0;

  function automatic bit min_digits_ok(input int unsigned n);
    return (n >= 1) && (n <= 4);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Keypad/control strobes and display/status outputs of the countdown timer.
// master: keypad/controller side, slave: timer side.
interface countdown_timer_if #(
  parameter int unsigned MIN_DIGITS = 2
);
  logic                    tick;
  logic [3:0]              digit;
  logic                    digit_valid;
  logic                    start;
  logic                    pause;
  logic                    cancel;
  logic                    add30;
  logic [4*MIN_DIGITS-1:0] minutes;
  logic [3:0]              tens_secs;
  logic [3:0]              secs;
  logic                    running;
  logic                    paused;
  logic                    timer_done;
  logic                    done_pulse;

  modport master (
    output tick, digit, digit_valid, start, pause, cancel, add30,
    input  minutes, tens_secs, secs, running, paused, timer_done, done_pulse
  );

  modport slave (
    input  tick, digit, digit_valid, start, pause, cancel, add30,
    output minutes, tens_secs, secs, running, paused, timer_done, done_pulse
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register.
// Ports: clk, clr (sync clear, top priority), load/load_val, shift/shift_in,
// dec (wraps 0 -> MAX), inc (wraps 9 -> 0), q (digit), zero_c (q == 0).
module bcd_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       shift,
  input  logic [3:0] shift_in,
  input  logic       dec,
  input  logic       inc,
  output logic [3:0] q,
  output logic       zero_c
);

  // Operation priority: clear > load > shift > decrement > increment
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shift_in;
    end else if (dec) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign zero_c = (q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// BCD cook timer: keypad entry, start/pause/cancel, +30 s and quick start.
// Ports: CLK, clear (sync active-high reset), bus (slave modport):
//   strobes tick/digit_valid/start/pause/cancel/add30, digit;
//   registered outputs minutes/tens_secs/secs, running/paused/timer_done/done_pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS  = 2,
  parameter bit          QUICK_START = 1'b1
) (
  input  logic               CLK,
  input  logic               clear,
  countdown_timer_if.slave   bus
);

  if (!min_digits_ok(MIN_DIGITS)) begin : g_bad_min_digits
    $error("countdown_timer: MIN_DIGITS must be in 1..4");
  end

  state_t state, state_next;

  logic       clr_c, shift_c, dec_c, add_c, qs_c;
  logic [3:0] secs_q, tens_q;
  logic       secs_zero_c, tens_zero_c;
  logic [3:0] min_q [MIN_DIGITS];
  logic [MIN_DIGITS-1:0] min_zero_c, min_nine_c, min_dec_c, min_inc_c;
  logic       value_zero_c, value_one_c, add_ok_c, carry_c, sat_c, digit_ok_c;
  logic [4:0] tens_sum_c;
  logic [3:0] tens_add_c;
  logic       borrow_c, ripple_c;

  // Value predicates
  assign value_zero_c = secs_zero_c & tens_zero_c & (&min_zero_c);
  assign value_one_c  = (secs_q == 4'd1) & tens_zero_c & (&min_zero_c);
  assign digit_ok_c   = (bus.digit <= BCD_MAX);

  // +30 s arithmetic on the tens digit; saturate when the minute chain would overflow
  assign add_ok_c   = (tens_q <= SEC_TENS_MAX);
  assign tens_sum_c = 5'(tens_q) + 5'(ADD30_TENS);
  assign carry_c    = (tens_sum_c >= 5'(SEC_TENS_WRAP));
  assign tens_add_c = carry_c ? 4'(tens_sum_c - 5'(SEC_TENS_WRAP)) : tens_sum_c[3:0];
  assign sat_c      = add_c & carry_c & (&min_nine_c);

  // State register and registered status outputs
  always_ff @(posedge CLK) begin
    if (clear) begin
      state          <= ST_IDLE;
      bus.running    <= 1'b0;
      bus.paused     <= 1'b0;
      bus.timer_done <= 1'b0;
      bus.done_pulse <= 1'b0;
    end else begin
      state          <= state_next;
      bus.running    <= (state_next == ST_RUN);
      bus.paused     <= (state_next == ST_PAUSE);
      bus.timer_done <= (state_next == ST_DONE);
      bus.done_pulse <= (state_next == ST_DONE) && (state != ST_DONE);
    end
  end

  // Next state and digit operations; strobe priority cancel > pause > start > add30 > digit > tick
  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    shift_c    = 1'b0;
    dec_c      = 1'b0;
    add_c      = 1'b0;
    qs_c       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.cancel) begin
          clr_c = 1'b1;
        end else if (bus.start) begin
          if (!value_zero_c) begin
            state_next = ST_RUN;
          end else if (QUICK_START) begin
            qs_c       = 1'b1;
            state_next = ST_RUN;
          end
        end else if (bus.add30) begin
          add_c = add_ok_c;
        end else if (bus.digit_valid) begin
          shift_c = digit_ok_c;
        end
      end
      ST_RUN: begin
        if (bus.cancel) begin
          clr_c      = 1'b1;
          state_next = ST_IDLE;
        end else if (bus.pause) begin
          state_next = ST_PAUSE;
        end else if (bus.add30) begin
          add_c = add_ok_c;
        end else if (bus.tick) begin
          dec_c = 1'b1;
          if (value_one_c) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.cancel) begin
          clr_c      = 1'b1;
          state_next = ST_IDLE;
        end else if (bus.start) begin
          state_next = ST_RUN;
        end else if (bus.add30) begin
          add_c = add_ok_c;
        end
      end
      ST_DONE: begin
        if (bus.start || bus.cancel || bus.digit_valid) begin
          clr_c      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Minute chain: borrow ripples through zero digits, carry ripples through nines
  always_comb begin
    min_dec_c = '0;
    min_inc_c = '0;
    borrow_c  = dec_c & secs_zero_c & tens_zero_c;
    ripple_c  = add_c & carry_c & ~sat_c;
    for (int i = 0; i < int'(MIN_DIGITS); i++) begin
      min_dec_c[i] = borrow_c;
      min_inc_c[i] = ripple_c;
      borrow_c     = borrow_c & min_zero_c[i];
      ripple_c     = ripple_c & min_nine_c[i];
    end
  end

  bcd_digit #(.MAX(BCD_MAX)) u_secs (
    .clk      (CLK),
    .clr      (clear | clr_c),
    .load     (qs_c | sat_c),
    .load_val (sat_c ? BCD_MAX : QS_SECS),
    .shift    (shift_c),
    .shift_in (bus.digit),
    .dec      (dec_c),
    .inc      (1'b0),
    .q        (secs_q),
    .zero_c   (secs_zero_c)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_tens (
    .clk      (CLK),
    .clr      (clear | clr_c),
    .load     (qs_c | add_c),
    .load_val (sat_c ? SEC_TENS_MAX : (qs_c ? QS_TENS : tens_add_c)),
    .shift    (shift_c),
    .shift_in (secs_q),
    .dec      (dec_c & secs_zero_c),
    .inc      (1'b0),
    .q        (tens_q),
    .zero_c   (tens_zero_c)
  );

  for (genvar i = 0; i < int'(MIN_DIGITS); i++) begin : g_min
    logic [3:0] shift_in_c;
    if (i == 0) begin : g_lsd
      assign shift_in_c = tens_q;
    end else begin : g_upper
      assign shift_in_c = min_q[i-1];
    end

    bcd_digit #(.MAX(BCD_MAX)) u_min (
      .clk      (CLK),
      .clr      (clear | clr_c),
      .load     (qs_c | sat_c),
      .load_val (sat_c ? BCD_MAX : 4'd0),
      .shift    (shift_c),
      .shift_in (shift_in_c),
      .dec      (min_dec_c[i]),
      .inc      (min_inc_c[i]),
      .q        (min_q[i]),
      .zero_c   (min_zero_c[i])
    );

    assign min_nine_c[i]        = (min_q[i] == BCD_MAX);
    assign bus.minutes[4*i +: 4] = min_q[i];
  end

  assign bus.tens_secs = tens_q;
  assign bus.secs      = secs_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random
// strobe stream checked against an integer-arithmetic timer model.
module tb_countdown_timer;

  localparam int unsigned MD   = 2;
  localparam int          MAXM = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic CLK = 1'b0;
  logic clear;
  always #5 CLK = ~CLK;

  countdown_timer_if #(.MIN_DIGITS(MD)) bus ();

  countdown_timer #(.MIN_DIGITS(MD), .QUICK_START(1'b1)) dut (
    .CLK   (CLK),
    .clear (clear),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: minutes as a plain integer, seconds digits as integers
  int m_min, m_tens, m_secs, m_st;
  bit m_pulse;

  function automatic void m_zero();
    m_min = 0; m_tens = 0; m_secs = 0;
  endfunction

  function automatic void m_add30();
    if (m_tens <= 5) begin
      m_tens += 3;
      if (m_tens >= 6) begin
        m_tens -= 6;
        if (m_min == MAXM) begin
          m_tens = 5; m_secs = 9;
        end else begin
          m_min++;
        end
      end
    end
  endfunction

  function automatic void m_tick();
    if (m_secs > 0) m_secs--;
    else begin
      m_secs = 9;
      if (m_tens > 0) m_tens--;
      else begin m_tens = 5; m_min--; end
    end
  endfunction

  function automatic void model(input bit clr, tk, dv, input int d, input bit st, pa, ca, a30);
    int prev = m_st;
    bit is_zero = (m_min == 0 && m_tens == 0 && m_secs == 0);
    if (clr) begin
      m_zero(); m_st = S_IDLE; m_pulse = 0;
      return;
    end
    case (m_st)
      S_IDLE: begin
        if (ca) m_zero();
        else if (st) begin
          if (is_zero) begin m_tens = 3; m_secs = 0; end
          m_st = S_RUN;
        end else if (a30) m_add30();
        else if (dv && d <= 9) begin
          m_min = (m_min * 10 + m_tens) % (MAXM + 1);
          m_tens = m_secs; m_secs = d;
        end
      end
      S_RUN: begin
        if (ca) begin m_zero(); m_st = S_IDLE; end
        else if (pa) m_st = S_PAUSE;
        else if (a30) m_add30();
        else if (tk) begin
          m_tick();
          if (m_min == 0 && m_tens == 0 && m_secs == 0) m_st = S_DONE;
        end
      end
      S_PAUSE: begin
        if (ca) begin m_zero(); m_st = S_IDLE; end
        else if (st) m_st = S_RUN;
        else if (a30) m_add30();
      end
      default: begin
        if (st || ca || dv) begin m_zero(); m_st = S_IDLE; end
      end
    endcase
    m_pulse = (m_st == S_DONE) && (prev != S_DONE);
  endfunction

  function automatic logic [15:0] exp_disp();
    logic [15:0] r;
    int v = m_min;
    r = {8'h00, 4'(m_tens), 4'(m_secs)};
    for (int i = 0; i < int'(MD); i++) begin
      r[8 + 4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_stat();
    return {m_st == S_RUN, m_st == S_PAUSE, m_st == S_DONE, m_pulse};
  endfunction

  function automatic logic [15:0] disp();
    return {bus.minutes, bus.tens_secs, bus.secs};
  endfunction

  function automatic logic [3:0] stat();
    return {bus.running, bus.paused, bus.timer_done, bus.done_pulse};
  endfunction

  // Apply one cycle of inputs, update the model, sample 1 time unit after the edge
  task automatic step(input bit clr, tk, dv, input logic [3:0] d, input bit st, pa, ca, a30);
    clear = clr; bus.tick = tk; bus.digit_valid = dv; bus.digit = d;
    bus.start = st; bus.pause = pa; bus.cancel = ca; bus.add30 = a30;
    model(clr, tk, dv, int'(d), st, pa, ca, a30);
    @(posedge CLK); #1;
    clear = 0; bus.tick = 0; bus.digit_valid = 0; bus.digit = 4'd0;
    bus.start = 0; bus.pause = 0; bus.cancel = 0; bus.add30 = 0;
  endtask

  task automatic do_clear();  step(1, 0, 0, 4'd0, 0, 0, 0, 0); endtask
  task automatic key(input logic [3:0] d); step(0, 0, 1, d, 0, 0, 0, 0); endtask
  task automatic do_start();  step(0, 0, 0, 4'd0, 1, 0, 0, 0); endtask
  task automatic do_cancel(); step(0, 0, 0, 4'd0, 0, 0, 1, 0); endtask
  task automatic do_add30();  step(0, 0, 0, 4'd0, 0, 0, 0, 1); endtask
  task automatic do_tick();   step(0, 1, 0, 4'd0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    do_clear();
    n_tests++;
    if (disp() !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", disp()); end
    n_tests++;
    if (stat() !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", stat()); end
  endtask

  task automatic test_entry_countdown();
    do_clear(); key(4'd1); key(4'd3); key(4'd0);
    n_tests++;
    if (disp() !== 16'h0130) begin n_fail++; $display("FAIL entry_130: got %h want 0130", disp()); end
    do_start();
    n_tests++;
    if (stat() !== 4'b1000) begin n_fail++; $display("FAIL start_run: got %b want 1000", stat()); end
    for (int i = 1; i <= 90; i++) begin
      do_tick();
      n_tests++;
      if (disp() !== exp_disp()) begin
        n_fail++; $display("FAIL countdown_tick%0d: got %h want %h", i, disp(), exp_disp());
      end
      if (i == 30) begin
        n_tests++;
        if (disp() !== 16'h0100) begin n_fail++; $display("FAIL at_100: got %h want 0100", disp()); end
      end
      if (i == 31) begin
        n_tests++;
        if (disp() !== 16'h0059) begin n_fail++; $display("FAIL at_059: got %h want 0059", disp()); end
      end
    end
    n_tests++;
    if (stat() !== 4'b0011) begin n_fail++; $display("FAIL done_entry: got %b want 0011", stat()); end
    step(0, 0, 0, 4'd0, 0, 0, 0, 0);
    n_tests++;
    if (stat() !== 4'b0010) begin n_fail++; $display("FAIL done_pulse_once: got %b want 0010", stat()); end
  endtask

  task automatic test_nonnormal();
    do_clear(); key(4'd9); key(4'd9); do_start();
    for (int i = 0; i < 10; i++) do_tick();
    n_tests++;
    if (disp() !== 16'h0089) begin n_fail++; $display("FAIL nonnorm_089: got %h want 0089", disp()); end
    for (int i = 0; i < 89; i++) do_tick();
    n_tests++;
    if (disp() !== 16'h0000 || stat() !== 4'b0011) begin
      n_fail++; $display("FAIL nonnorm_done: got %h/%b want 0000/0011", disp(), stat());
    end
  endtask

  task automatic test_pause_add30();
    do_clear(); key(4'd2); key(4'd1); key(4'd0); do_start();
    for (int i = 0; i < 5; i++) do_tick();
    n_tests++;
    if (disp() !== 16'h0205) begin n_fail++; $display("FAIL run_205: got %h want 0205", disp()); end
    step(0, 1, 0, 4'd0, 0, 1, 0, 0);
    n_tests++;
    if (disp() !== 16'h0205 || stat() !== 4'b0100) begin
      n_fail++; $display("FAIL pause_tick: got %h/%b want 0205/0100", disp(), stat());
    end
    for (int i = 0; i < 3; i++) do_tick();
    key(4'd7);
    n_tests++;
    if (disp() !== 16'h0205) begin n_fail++; $display("FAIL pause_hold: got %h want 0205", disp()); end
    do_add30();
    n_tests++;
    if (disp() !== 16'h0235 || stat() !== 4'b0100) begin
      n_fail++; $display("FAIL pause_add30: got %h/%b want 0235/0100", disp(), stat());
    end
    do_start(); do_tick();
    n_tests++;
    if (disp() !== 16'h0234 || stat() !== 4'b1000) begin
      n_fail++; $display("FAIL resume: got %h/%b want 0234/1000", disp(), stat());
    end
    step(0, 1, 0, 4'd0, 0, 0, 0, 1);
    n_tests++;
    if (disp() !== 16'h0304) begin n_fail++; $display("FAIL add30_beats_tick: got %h want 0304", disp()); end
  endtask

  task automatic test_quick_saturate();
    do_clear(); do_start();
    n_tests++;
    if (disp() !== 16'h0030 || stat() !== 4'b1000) begin
      n_fail++; $display("FAIL quick_start: got %h/%b want 0030/1000", disp(), stat());
    end
    do_cancel(); key(4'd9); key(4'd9); key(4'd4); key(4'd5); do_add30();
    n_tests++;
    if (disp() !== 16'h9959) begin n_fail++; $display("FAIL saturate: got %h want 9959", disp()); end
    do_clear(); key(4'd9); key(4'd9); key(4'd2); key(4'd0); do_add30();
    n_tests++;
    if (disp() !== 16'h9950) begin n_fail++; $display("FAIL add30_9920: got %h want 9950", disp()); end
    do_clear(); key(4'd1); key(4'd9); key(4'd4); key(4'd0); do_add30();
    n_tests++;
    if (disp() !== 16'h2010) begin n_fail++; $display("FAIL add30_carry: got %h want 2010", disp()); end
  endtask

  task automatic test_digit_overflow();
    do_clear();
    for (int i = 1; i <= 5; i++) key(4'(i));
    n_tests++;
    if (disp() !== 16'h2345) begin n_fail++; $display("FAIL shift_overflow: got %h want 2345", disp()); end
    key(4'hC);
    n_tests++;
    if (disp() !== 16'h2345) begin n_fail++; $display("FAIL illegal_digit: got %h want 2345", disp()); end
  endtask

  task automatic test_cancel_clear();
    do_clear(); key(4'd4); key(4'd5); do_start();
    for (int i = 0; i < 5; i++) do_tick();
    n_tests++;
    if (disp() !== 16'h0040) begin n_fail++; $display("FAIL run_040: got %h want 0040", disp()); end
    do_cancel();
    n_tests++;
    if (disp() !== 16'h0000 || stat() !== 4'b0000) begin
      n_fail++; $display("FAIL cancel_run: got %h/%b want 0000/0000", disp(), stat());
    end
    key(4'd3); do_start();
    for (int i = 0; i < 3; i++) do_tick();
    do_clear();
    n_tests++;
    if (disp() !== 16'h0000 || stat() !== 4'b0000) begin
      n_fail++; $display("FAIL clear_done: got %h/%b want 0000/0000", disp(), stat());
    end
    key(4'd2); do_start(); do_tick(); do_tick();
    n_tests++;
    if (stat() !== 4'b0011) begin n_fail++; $display("FAIL done_again: got %b want 0011", stat()); end
    key(4'd7);
    n_tests++;
    if (disp() !== 16'h0000 || stat() !== 4'b0000) begin
      n_fail++; $display("FAIL done_digit_exit: got %h/%b want 0000/0000", disp(), stat());
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0);
      n_tests++;
      if (disp() !== exp_disp() || stat() !== exp_stat()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h/%b want %h/%b", i, disp(), stat(), exp_disp(), exp_stat());
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    bus.tick = 0; bus.digit = 4'd0; bus.digit_valid = 0;
    bus.start = 0; bus.pause = 0; bus.cancel = 0; bus.add30 = 0;
    m_zero(); m_st = S_IDLE; m_pulse = 0;
    test_reset();
    test_entry_countdown();
    test_nonnormal();
    test_pause_add30();
    test_quick_saturate();
    test_digit_overflow();
    test_cancel_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
